dl_shift_pipe: RTL and testbench

Parameterised, pipelined barrel shifter with valid/ready handshakes on both sides. It supports logical left, logical right, arithmetic right and rotate-left modes. It generalises the single-mode combinational left shifter into a multi-stage unit with configurable depth and back-pressure. Intended for the execute stage and for any datapath that needs a registered shift with flow control.

---
 rtl/dl_shift_pkg.sv | 23 ++
 rtl/dl_shift_stage.sv | 41 ++++
 rtl/dl_shift_pipe.sv | 125 ++++++++++++
 tb/tb_dl_shift_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and the
// mapping from pipeline stage to the shift levels it implements.
package dl_shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef struct packed {
    logic [7:0] first;
    logic [7:0] last;
  } level_range_t;

  // Stage s of st covers levels floor(s*l/st) .. floor((s+1)*l/st)-1.
  function automatic level_range_t stage_levels(input int s, input int l, input int st);
    level_range_t r;
    r.first = 8'((s * l) / st);
    r.last  = 8'(((s + 1) * l) / st - 1);
    return r;
  endfunction

endpackage

// File: rtl/dl_shift_stage.sv
// Combinational slice of the barrel shifter: applies shift levels
// FIRST_LEVEL..LAST_LEVEL (level k moves by 2^k) for the selected op.
module dl_shift_stage
  import dl_shift_pkg::*;
#(
  parameter int NUM_BITS    = 32,
  parameter int FIRST_LEVEL = 0,
  parameter int LAST_LEVEL  = 0,
  localparam int NUM_LEVELS = LAST_LEVEL - FIRST_LEVEL + 1
) (
  input  logic [NUM_BITS-1:0]   data,
  input  logic [NUM_LEVELS-1:0] shift,
  input  logic [1:0]            op,
  input  logic                  fill,
  output logic [NUM_BITS-1:0]   result
);

  localparam logic [NUM_BITS-1:0] ONES = '1;

  always_comb begin
    logic [NUM_BITS-1:0] d;
    int amt;
    // NOTE: every variable gets a value before any conditional path, so no latch is inferred.
    d   = data;
    amt = 0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      amt = 1 << (FIRST_LEVEL + i);
      if (shift[i]) begin
        case (op)
          OP_SLL: d = d << amt;
          OP_SRL: d = d >> amt;
          // Sign bit was captured at entry, so later stages fill correctly.
          OP_SRA: d = (d >> amt) | ({NUM_BITS{fill}} & ~(ONES >> amt));
          OP_ROL: d = (d << amt) | (d >> (NUM_BITS - amt));
        endcase
      end
    end
    result = d;
  end

endmodule

// File: rtl/dl_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready on both sides;
// each stage applies a slice of the shift levels and ends in a register.
module dl_shift_pipe
  import dl_shift_pkg::*;
#(
  parameter int  NUM_BITS       = 32,
  parameter int  NUM_STAGES     = 2,
  parameter int  TAG_BITS       = 4,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [NUM_BITS-1:0]       in_a,
  input  logic [NUM_SHIFT_BITS-1:0] in_shift,
  input  logic [1:0]                in_op,
  input  logic [TAG_BITS-1:0]       in_tag,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [NUM_BITS-1:0]       out_data,
  output logic [TAG_BITS-1:0]       out_tag
);

  if (NUM_BITS < 2 || (NUM_BITS & (NUM_BITS - 1)) != 0) begin : g_bad_bits
    $fatal(1, "dl_shift_pipe: NUM_BITS must be a power of two >= 2");
  end
  if (NUM_STAGES < 1 || NUM_STAGES > NUM_SHIFT_BITS) begin : g_bad_stages
    $fatal(1, "dl_shift_pipe: NUM_STAGES must be in 1..NUM_SHIFT_BITS");
  end
  if (TAG_BITS < 1) begin : g_bad_tag
    $fatal(1, "dl_shift_pipe: TAG_BITS must be >= 1");
  end

  typedef struct packed {
    logic [NUM_SHIFT_BITS-1:0] shift;
    logic [1:0]                op;
    logic                      fill;
  } ctl_t;

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_BITS-1:0]   data_q [NUM_STAGES];
  logic [TAG_BITS-1:0]   tag_q  [NUM_STAGES];
  ctl_t                  ctl_q  [NUM_STAGES];

  logic [NUM_STAGES-1:0] val_in;
  logic [NUM_BITS-1:0]   data_in [NUM_STAGES];
  logic [NUM_BITS-1:0]   data_sh [NUM_STAGES];
  logic [TAG_BITS-1:0]   tag_in  [NUM_STAGES];
  ctl_t                  ctl_in  [NUM_STAGES];
  logic [NUM_STAGES-1:0] ld;

  // Stage inputs: stage 0 from the ports, stage s from register s-1.
  always_comb begin
    val_in[0]  = in_val;
    data_in[0] = in_a;
    tag_in[0]  = in_tag;
    ctl_in[0]  = '{shift: in_shift, op: in_op, fill: in_a[NUM_BITS-1]};
    for (int s = 1; s < NUM_STAGES; s++) begin
      val_in[s]  = valid_q[s-1];
      data_in[s] = data_q[s-1];
      tag_in[s]  = tag_q[s-1];
      ctl_in[s]  = ctl_q[s-1];
    end
  end

  // A stage loads when empty or when its successor loads; the output
  // side's "successor" is out_rdy. Walked from the back of the pipe.
  always_comb begin
    logic nxt;
    nxt = out_rdy;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      ld[s] = !valid_q[s] || nxt;
      nxt   = ld[s];
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam level_range_t RANGE = stage_levels(s, NUM_SHIFT_BITS, NUM_STAGES);
    localparam int FIRST = int'(RANGE.first);
    localparam int LAST  = int'(RANGE.last);

    dl_shift_stage #(
      .NUM_BITS   (NUM_BITS),
      .FIRST_LEVEL(FIRST),
      .LAST_LEVEL (LAST)
    ) u_stage (
      .data  (data_in[s]),
      .shift (ctl_in[s].shift[LAST:FIRST]),
      .op    (ctl_in[s].op),
      .fill  (ctl_in[s].fill),
      .result(data_sh[s])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: these are pipeline registers rather than a storage array, so all of them are reset; out_data/out_tag must read 0.
      for (int s = 0; s < NUM_STAGES; s++) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        tag_q[s]   <= '0;
        ctl_q[s]   <= '0;
      end
    end else begin
      // NOTE: non-blocking updates let each stage capture its predecessor's pre-edge contents.
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (ld[s]) begin
          valid_q[s] <= val_in[s];
          if (val_in[s]) begin
            data_q[s] <= data_sh[s];
            tag_q[s]  <= tag_in[s];
            ctl_q[s]  <= ctl_in[s];
          end
        end
      end
    end
  end

  assign in_rdy   = ld[0];
  assign out_val  = valid_q[NUM_STAGES-1];
  assign out_data = data_q[NUM_STAGES-1];
  assign out_tag  = tag_q[NUM_STAGES-1];

endmodule

// File: tb/tb_dl_shift_pipe.sv
// Self-checking bench for dl_shift_pipe: directed vectors plus a random stream,
// scored against an arithmetic model of the four shift modes.
module tb_dl_shift_pipe;
  import dl_shift_pkg::*;

  localparam int NUM_BITS   = 32;
  localparam int NUM_STAGES = 2;
  localparam int TAG_BITS   = 4;
  localparam int SB         = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_val;
  logic                in_rdy;
  logic [NUM_BITS-1:0] in_a;
  logic [SB-1:0]       in_shift;
  logic [1:0]          in_op;
  logic [TAG_BITS-1:0] in_tag;
  logic                out_val;
  logic                out_rdy;
  logic [NUM_BITS-1:0] out_data;
  logic [TAG_BITS-1:0] out_tag;

  dl_shift_pipe #(
    .NUM_BITS  (NUM_BITS),
    .NUM_STAGES(NUM_STAGES),
    .TAG_BITS  (TAG_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_a    (in_a),
    .in_shift(in_shift),
    .in_op   (in_op),
    .in_tag  (in_tag),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_data(out_data),
    .out_tag (out_tag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit lat_check = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NUM_BITS-1:0] data;
    logic [TAG_BITS-1:0] tag;
    int                  acc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input int sh, input logic [1:0] op);
    logic [63:0] rr;
    case (op)
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return 32'($signed(a) >>> sh);
      default: begin
        rr = {a, a} << sh;
        return rr[63:32];
      end
    endcase
  endfunction

  // Compare process: mid-cycle, every handshake is scored against the model.
  bit                  prev_stalled = 1'b0;
  logic [NUM_BITS-1:0] prev_data;
  logic [TAG_BITS-1:0] prev_tag;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled) begin
        check("hold_val", out_val, 1);
        check("hold_data", out_data, prev_data);
        check("hold_tag", out_tag, prev_tag);
      end
      if (out_val && out_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_val, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_tag", out_tag, e.tag);
          if (lat_check) check("latency", cyc - e.acc, NUM_STAGES);
        end
      end
      if (in_val && in_rdy)
        sb.push_back('{model(in_a, int'(in_shift), in_op), in_tag, cyc});
      prev_stalled = out_val && !out_rdy;
      prev_data    = out_data;
      prev_tag     = out_tag;
    end
  end

  task automatic drive_cycle(output bit acc);
    @(negedge clk);
    acc = in_val && in_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input int sh, input logic [1:0] op, input logic [3:0] tag);
    bit acc;
    int n;
    in_a = a; in_shift = SB'(sh); in_op = op; in_tag = tag; in_val = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      drive_cycle(acc);
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    in_val = 1'b0;
    out_rdy = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_val) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  logic [31:0] mode_exp [4] = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F, 32'h0000_0F18};

  initial begin
    bit acc;
    int sent;
    int cycles;
    int tag_next;

    rst_n = 1'b0; in_val = 1'b0; in_a = '0; in_shift = '0; in_op = '0; in_tag = '0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_val", out_val, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_rdy", in_rdy, 1);
    repeat (2) @(posedge clk);
    #1;
    check("idle_out_val", out_val, 0);
    check("idle_in_rdy", in_rdy, 1);

    // Pin the model to hand-computed results before trusting it.
    for (int op = 0; op < 4; op++)
      check($sformatf("model_mode%0d", op), model(32'h8000_00F1, 4, 2'(op)), mode_exp[op]);
    check("model_sll31", model(32'h1, 31, OP_SLL), 32'h8000_0000);
    check("model_sra31", model(32'h8000_0000, 31, OP_SRA), 32'hFFFF_FFFF);
    check("model_rol31", model(32'h1, 31, OP_ROL), 32'h8000_0000);
    check("model_srl0", model(32'hA5C3_1E07, 0, OP_SRL), 32'hA5C3_1E07);

    // Mode coverage and boundaries, back-to-back, no stall.
    out_rdy = 1'b1;
    lat_check = 1'b1;
    for (int op = 0; op < 4; op++) send(32'h8000_00F1, 4, 2'(op), 4'(op + 1));
    for (int op = 0; op < 4; op++) send(32'hA5C3_1E07, 0, 2'(op), 4'(op + 8));
    send(32'h1, 31, OP_SLL, 4'hC);
    send(32'h8000_0000, 31, OP_SRA, 4'hD);
    send(32'h1, 31, OP_ROL, 4'hE);
    drain();
    lat_check = 1'b0;

    // Back-pressure: only two operations fit while the output is blocked.
    out_rdy = 1'b0;
    tag_next = 0;
    for (int i = 0; i < 5; i++) begin
      in_a = 32'h1234_5670 + 32'(tag_next); in_shift = SB'(tag_next + 1); in_op = 2'(tag_next);
      in_tag = 4'(tag_next); in_val = 1'b1;
      drive_cycle(acc);
      if (acc) tag_next++;
    end
    check("bp_accepts", tag_next, 2);
    check("bp_in_rdy", in_rdy, 0);
    out_rdy = 1'b1;
    #1;
    check("bp_release_in_rdy", in_rdy, 1);
    cycles = 0;
    while (tag_next < 8 && cycles < 100) begin
      in_a = 32'h1234_5670 + 32'(tag_next); in_shift = SB'(tag_next + 1); in_op = 2'(tag_next);
      in_tag = 4'(tag_next); in_val = 1'b1;
      drive_cycle(acc);
      if (acc) tag_next++;
      cycles++;
    end
    check("bp_all_sent", tag_next, 8);
    drain();

    // Random traffic on both handshakes.
    sent = 0;
    cycles = 0;
    while (sent < 10000 && cycles < 60000) begin
      in_val = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      in_a = $urandom;
      in_shift = SB'($urandom_range(0, 31));
      in_op = 2'($urandom_range(0, 3));
      in_tag = 4'($urandom_range(0, 15));
      drive_cycle(acc);
      if (acc) sent++;
      cycles++;
    end
    check("rand_sent", sent, 10000);
    drain();

    // Reset with two operations in flight.
    send(32'hDEAD_BEEF, 3, OP_SRL, 4'h1);
    send(32'hCAFE_F00D, 5, OP_SLL, 4'h2);
    in_val = 1'b0;
    rst_n = 1'b0;
    drive_cycle(acc);
    rst_n = 1'b1;
    check("midrst_out_val", out_val, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_idle_val", out_val, 0);
    send(32'h0F0F_0001, 7, OP_ROL, 4'h9);
    in_val = 1'b0;
    for (int i = 0; i < 10 && !out_val; i++) begin
      @(posedge clk);
      #1;
    end
    check("first_after_rst_val", out_val, 1);
    check("first_after_rst_tag", out_tag, 4'h9);
    check("first_after_rst_data", out_data, 32'h8780_0087);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
